clk_char_monitor: RTL
=====================

// Module: clk_char_monitor
// PURPOSE
//  Measures a clock-like input: high time, low time, period and phase offset
//  versus a reference edge. All results are counted in cycles of the sampling clock clk.
//  Checker counterpart to the bench clock generators (phase/ton/toff). Used in TBs and as a
//  synthesizable on-chip clock monitor; sig_in/ref_in are asynchronous to clk.
// PARAMETERS
//  CNT_W        16  width of ton/toff/phase counters; period is CNT_W+1 bits
//  SYNC_STAGES  2   flop stages on sig_in and ref_in (min 2)
// PORTS
//  clk         in   1        sampling clock (e.g. 100 MHz -> 10 ns resolution)
//  rst_n       in   1        async active-low reset
//  start       in   1        1-cycle pulse: begin one measurement
//  sig_in      in   1        clock under test, async
//  ref_in      in   1        phase reference, async
//  busy        out  1        measurement in progress
//  done        out  1        1-cycle pulse: results valid/updated
//  timeout     out  1        last measurement aborted by saturation; held until next start
//  ton_cnt     out  CNT_W    high-time cycles
//  toff_cnt    out  CNT_W    low-time cycles
//  period_cnt  out  CNT_W+1  ton_cnt+toff_cnt
//  phase_cnt   out  CNT_W    ref rise -> sig rise cycles
//  exp_period  in   CNT_W+1  [CLKMON_CHECK_EN only] expected period
//  tol         in   CNT_W    [CLKMON_CHECK_EN only] allowed |period-exp_period|
//  in_spec     out  1        [CLKMON_CHECK_EN only] period within tolerance
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0; sync chains 0.
//  sig_in/ref_in use identical SYNC_STAGES chains, so latency cancels in all counts.
//  Edge detect: rise = sync & ~prev, fall = ~sync & prev. Edges are seen SYNC_STAGES+1 cycles after the pin.
//  FSM:
//   IDLE:      on start -> WAIT_REF; busy=1; timeout cleared; counters cleared.
//   WAIT_REF:  on ref rise -> WAIT_RISE, phase counter starts at 0.
//              Same cycle ref rise + sig rise -> phase=0, go straight to MEAS_HIGH.
//   WAIT_RISE: phase++ each cycle; on sig rise -> MEAS_HIGH.
//   MEAS_HIGH: ton++ each cycle incl. the rise cycle; on sig fall -> MEAS_LOW.
//   MEAS_LOW:  toff++ each cycle incl. the fall cycle; on next sig rise -> DONE.
//   DONE:      one cycle; results registered; done=1; busy=0; -> IDLE.
//  Results:
//   ton/toff/phase/period update only in DONE and hold until the next DONE.
//   period = zero-extended ton + toff, no overflow.
//  Timeout:
//   Any active counter reaching 2^CNT_W-1 (incl. a wait in WAIT_REF) -> DONE with timeout=1.
//   Counts hold saturated/partial values.
//  start while busy: ignored. start in the DONE cycle: ignored.
//  Reset mid-operation: immediate IDLE; outputs back to 0; no done pulse.
//  Glitches shorter than one clk period may be missed; no filtering.
// CONFIGURATION
//  CLKMON_CHECK_EN defined:
//   exp_period/tol/in_spec ports exist.
//   in_spec is registered in DONE: 1 iff !timeout && |period-exp_period| <= tol.
//   Cleared on start; 0 at reset.
//  CLKMON_CHECK_EN undefined: those ports and the logic are absent; other behaviour identical.
// TESTING
//  (clk 100 MHz; TB drives sig/ref edges 1 ns after clk posedge for deterministic sampling.)
//  1. sig 5 MHz 50% (100 ns hi / 100 ns lo), ref aligned to sig
//     -> phase=0, ton=10, toff=10, period=20, done pulses once, timeout=0.
//  2. sig 80 ns period, 20 ns high; ref rises 40 ns before sig
//     -> phase=4, ton=2, toff=6, period=8.
//  3. CNT_W=8, sig stuck low after ref rise
//     -> after 255 cycles in WAIT_RISE: done=1, timeout=1, phase=255.
//  4. Reset asserted during MEAS_HIGH
//     -> busy=0, done never pulses, all outputs 0.
//     -> next start with test-1 stimulus gives ton=10.
//  5. start re-pulsed while busy
//     -> ignored; single done pulse; results match test 1.
//  6. CLKMON_CHECK_EN, exp_period=20, tol=1
//     -> test-1 stimulus: in_spec=1.
//     -> sig 220 ns period (period=22): in_spec=0.

Source files
------------

// File: rtl/clk_char_monitor_if.sv
// Bundle of the clk_char_monitor control, stimulus and result signals.
//
// Optional macro: CLKMON_CHECK_EN adds exp_period/tol/in_spec.
//
// Signals (direction as seen by the monitor, i.e. the slave modport):
//   start      in   1-cycle pulse, begin one measurement
//   sig_in     in   clock under test (async to clk)
//   ref_in     in   phase reference (async to clk)
//   busy       out  measurement in progress
//   done       out  1-cycle pulse, results updated
//   timeout    out  last measurement aborted by counter saturation
//   ton_cnt    out  high-time cycles
//   toff_cnt   out  low-time cycles
//   period_cnt out  ton_cnt + toff_cnt (one bit wider)
//   phase_cnt  out  ref rise -> sig rise cycles
//   exp_period in   expected period              [CLKMON_CHECK_EN]
//   tol        in   allowed |period-exp_period|  [CLKMON_CHECK_EN]
//   in_spec    out  period within tolerance      [CLKMON_CHECK_EN]
interface clk_char_monitor_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             sig_in;
    logic             ref_in;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] ton_cnt;
    logic [CNT_W-1:0] toff_cnt;
    logic [CNT_W:0]   period_cnt;
    logic [CNT_W-1:0] phase_cnt;
`ifdef CLKMON_CHECK_EN
    logic [CNT_W:0]   exp_period;
    logic [CNT_W-1:0] tol;
    logic             in_spec;

    modport master (
        output start, sig_in, ref_in, exp_period, tol,
        input  busy, done, timeout, ton_cnt, toff_cnt, period_cnt, phase_cnt, in_spec
    );
    modport slave (
        input  start, sig_in, ref_in, exp_period, tol,
        output busy, done, timeout, ton_cnt, toff_cnt, period_cnt, phase_cnt, in_spec
    );
`else
    modport master (
        output start, sig_in, ref_in,
        input  busy, done, timeout, ton_cnt, toff_cnt, period_cnt, phase_cnt
    );
    modport slave (
        input  start, sig_in, ref_in,
        output busy, done, timeout, ton_cnt, toff_cnt, period_cnt, phase_cnt
    );
`endif
endinterface

// File: rtl/clk_char_monitor.sv
// clk_char_monitor: measures high time, low time, period and phase offset (versus a
// reference rising edge) of an asynchronous clock-like input, in cycles of clk.
//
// Optional macro: CLKMON_CHECK_EN adds a registered period-within-tolerance flag.
//
// Ports:
//   clk    sampling clock
//   rst_n  asynchronous active-low reset
//   bus    clk_char_monitor_if.slave (start/sig_in/ref_in in, status and counts out)
//
// Parameters:
//   CNT_W        width of ton/toff/phase counters; period is CNT_W+1 bits
//   SYNC_STAGES  synchroniser depth on sig_in and ref_in (minimum 2)
module clk_char_monitor #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rst_n,
    clk_char_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitRef,
        StWaitRise,
        StMeasHigh,
        StMeasLow,
        StDone
    } state_e;

    // Identical chains on both inputs so synchroniser latency cancels in every count.
    logic [SYNC_STAGES-1:0] sig_sync_q, ref_sync_q;
    logic                   sig_prev_q, ref_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_sync_q <= '0;
            ref_sync_q <= '0;
            sig_prev_q <= 1'b0;
            ref_prev_q <= 1'b0;
        end else begin
            sig_sync_q <= {sig_sync_q[SYNC_STAGES-2:0], bus.sig_in};
            ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], bus.ref_in};
            sig_prev_q <= sig_sync_q[SYNC_STAGES-1];
            ref_prev_q <= ref_sync_q[SYNC_STAGES-1];
        end
    end

    logic sig_rise, sig_fall, ref_rise;
    assign sig_rise = sig_sync_q[SYNC_STAGES-1] & ~sig_prev_q;
    assign sig_fall = ~sig_sync_q[SYNC_STAGES-1] & sig_prev_q;
    assign ref_rise = ref_sync_q[SYNC_STAGES-1] & ~ref_prev_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] ton_q, ton_d;
    logic [CNT_W-1:0] toff_q, toff_d;
    logic             finish;    // enter StDone on the next edge
    logic             sat;       // finishing because a counter saturated
    logic [CNT_W:0]   period_d;

    logic             busy_q, done_q, timeout_q;
    logic [CNT_W-1:0] ton_cnt_q, toff_cnt_q, phase_cnt_q;
    logic [CNT_W:0]   period_cnt_q;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        phase_d = phase_q;
        ton_d   = ton_q;
        toff_d  = toff_q;
        finish  = 1'b0;
        sat     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StWaitRef;
                    wait_d  = '0;
                    phase_d = '0;
                    ton_d   = '0;
                    toff_d  = '0;
                end
            end
            StWaitRef: begin
                if (ref_rise) begin
                    phase_d = '0;
                    // Coincident edges: zero phase, and this cycle is the first high cycle.
                    if (sig_rise) begin
                        ton_d   = CNT_W'(1);
                        state_d = StMeasHigh;
                    end else begin
                        state_d = StWaitRise;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_d == CntMax) begin
                        finish = 1'b1;
                        sat    = 1'b1;
                    end
                end
            end
            StWaitRise: begin
                phase_d = phase_q + 1'b1;
                if (phase_d == CntMax) begin
                    finish = 1'b1;
                    sat    = 1'b1;
                end else if (sig_rise) begin
                    ton_d   = CNT_W'(1);
                    state_d = StMeasHigh;
                end
            end
            StMeasHigh: begin
                if (sig_fall) begin
                    toff_d  = CNT_W'(1);
                    state_d = StMeasLow;
                end else begin
                    ton_d = ton_q + 1'b1;
                    if (ton_d == CntMax) begin
                        finish = 1'b1;
                        sat    = 1'b1;
                    end
                end
            end
            StMeasLow: begin
                if (sig_rise) begin
                    finish = 1'b1;
                end else begin
                    toff_d = toff_q + 1'b1;
                    if (toff_d == CntMax) begin
                        finish = 1'b1;
                        sat    = 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (finish) begin
            state_d = StDone;
        end
    end

    assign period_d = {1'b0, ton_d} + {1'b0, toff_d};

`ifdef CLKMON_CHECK_EN
    logic           in_spec_q;
    logic [CNT_W:0] diff;
    logic           within;

    always_comb begin
        diff   = (period_d >= bus.exp_period) ? (period_d - bus.exp_period)
                                              : (bus.exp_period - period_d);
        within = (diff <= {1'b0, bus.tol});
    end
`endif

    // Results are loaded on the edge that enters StDone, so done and the new counts
    // appear together for exactly the StDone cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wait_q       <= '0;
            phase_q      <= '0;
            ton_q        <= '0;
            toff_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            ton_cnt_q    <= '0;
            toff_cnt_q   <= '0;
            period_cnt_q <= '0;
            phase_cnt_q  <= '0;
`ifdef CLKMON_CHECK_EN
            in_spec_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            phase_q <= phase_d;
            ton_q   <= ton_d;
            toff_q  <= toff_d;
            done_q  <= finish;
            if (state_q == StIdle && bus.start) begin
                busy_q    <= 1'b1;
                timeout_q <= 1'b0;
`ifdef CLKMON_CHECK_EN
                in_spec_q <= 1'b0;
`endif
            end
            if (finish) begin
                busy_q       <= 1'b0;
                timeout_q    <= sat;
                ton_cnt_q    <= ton_d;
                toff_cnt_q   <= toff_d;
                period_cnt_q <= period_d;
                phase_cnt_q  <= phase_d;
`ifdef CLKMON_CHECK_EN
                in_spec_q    <= ~sat & within;
`endif
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.ton_cnt    = ton_cnt_q;
    assign bus.toff_cnt   = toff_cnt_q;
    assign bus.period_cnt = period_cnt_q;
    assign bus.phase_cnt  = phase_cnt_q;
`ifdef CLKMON_CHECK_EN
    assign bus.in_spec    = in_spec_q;
`endif

endmodule
